// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide scheduler: runs MULT/MULTU internally and sequences an external divider.
// Build option MULDIV_DIV0_FAST_EN: a zero divisor completes at once with hi=dividend, lo=all ones.
module muldiv_sched (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] opa_i,
   input  logic [31:0] opb_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        done_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div_start_o,
   output logic        div_signed_o,
   output logic        div_annul_o,
   output logic [31:0] div_a_o,
   output logic [31:0] div_b_o,
   input  logic        div_ready_i,
   input  logic [63:0] div_result_i
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      MUL1     = 3'd1,
      MUL2     = 3'd2,
      DIV_WAIT = 3'd3,
      DONE     = 3'd4
   } state_t;

   localparam logic [1:0] OP_DIV = 2'b10;

   state_t      state_r, state_s;
   logic [1:0]  op_r;
   logic [31:0] a_r, b_r, hi_r, lo_r;
   logic [63:0] prod_r, prod_s, hilo_s;
   logic        accept_s, load_s, div0_s;

   function automatic logic [63:0] ext64(input logic [31:0] v, input logic sgn);
      return {{32{sgn & v[31]}}, v};
   endfunction

   // Low 64 bits of the extended product are exact for both signed and unsigned operands
   assign prod_s = ext64(a_r, ~op_r[0]) * ext64(b_r, ~op_r[0]);

`ifdef MULDIV_DIV0_FAST_EN
   assign div0_s = op_i[1] & (opb_i == 32'd0);
`else
   assign div0_s = 1'b0;
`endif

   // Next-state selection and the single HI/LO load point (the edge entering DONE)
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      load_s   = 1'b0;
      hilo_s   = prod_r;
      case (state_r)
         IDLE: begin
            if (start_i && !flush_i) begin
               accept_s = 1'b1;
               if (!op_i[1]) begin
                  state_s = MUL1;
               end else if (div0_s) begin
                  state_s = DONE;
                  load_s  = 1'b1;
                  hilo_s  = {opa_i, 32'hFFFF_FFFF};
               end else begin
                  state_s = DIV_WAIT;
               end
            end else begin
               state_s = IDLE;
            end
         end
         MUL1: begin
            if (flush_i) state_s = IDLE;
            else         state_s = MUL2;
         end
         MUL2: begin
            if (flush_i) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
               load_s  = 1'b1;
               hilo_s  = prod_r;
            end
         end
         DIV_WAIT: begin
            // flush wins over a coincident divider result
            if (flush_i) begin
               state_s = IDLE;
            end else if (div_ready_i) begin
               state_s = DONE;
               load_s  = 1'b1;
               hilo_s  = div_result_i;
            end else begin
               state_s = DIV_WAIT;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   assign stall_o      = rst_ni & (accept_s | (state_r == MUL1) | (state_r == MUL2) | (state_r == DIV_WAIT));
   assign done_o       = (state_r == DONE);
   assign div_start_o  = (state_r == DIV_WAIT) & ~flush_i;
   assign div_annul_o  = (state_r == DIV_WAIT) & flush_i;
   assign div_signed_o = (state_r == DIV_WAIT) & (op_r == OP_DIV);
   assign div_a_o      = a_r;
   assign div_b_o      = b_r;
   assign hi_o         = hi_r;
   assign lo_o         = lo_r;

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_r <= IDLE;
      else         state_r <= state_s;
   end

   // Operation and operands captured on acceptance
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_r <= 2'b00;
         a_r  <= 32'd0;
         b_r  <= 32'd0;
      end else if (accept_s) begin
         op_r <= op_i;
         a_r  <= opa_i;
         b_r  <= opb_i;
      end else begin
         op_r <= op_r;
         a_r  <= a_r;
         b_r  <= b_r;
      end
   end

   // Product register, written during MUL1
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                prod_r <= 64'd0;
      else if (state_r == MUL1)   prod_r <= prod_s;
      else                        prod_r <= prod_r;
   end

   // Architectural HI/LO result registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_r <= 32'd0;
         lo_r <= 32'd0;
      end else if (load_s) begin
         hi_r <= hilo_s[63:32];
         lo_r <= hilo_s[31:0];
      end else begin
         hi_r <= hi_r;
         lo_r <= lo_r;
      end
   end

endmodule

// File: tb/tb_muldiv_sched.sv
// Randomized self-checking bench for muldiv_sched with a transaction-level reference model
// and a latency-programmable divider environment.
module tb_muldiv_sched;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        start_i = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [31:0] opa_i = 32'd0, opb_i = 32'd0;
   logic        flush_i = 1'b0;
   logic        div_ready_i = 1'b0;
   logic [63:0] div_result_i = 64'd0;
   logic        stall_o, done_o, div_start_o, div_signed_o, div_annul_o;
   logic [31:0] hi_o, lo_o, div_a_o, div_b_o;

`ifdef MULDIV_DIV0_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   muldiv_sched dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
      .opa_i(opa_i), .opb_i(opb_i), .flush_i(flush_i),
      .stall_o(stall_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o),
      .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_annul_o(div_annul_o),
      .div_a_o(div_a_o), .div_b_o(div_b_o),
      .div_ready_i(div_ready_i), .div_result_i(div_result_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference arithmetic, written directly from the operation definitions
   function automatic logic [63:0] mul_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      sa = (op == 2'b00) ? longint'($signed(a)) : longint'({32'd0, a});
      sb = (op == 2'b00) ? longint'($signed(b)) : longint'({32'd0, b});
      p  = sa * sb;
      return p;
   endfunction

   function automatic logic [63:0] div_ref(input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] qv, rv;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      q = sa / sb;
      r = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
   endfunction

   // ---------------- reference model ----------------
   bit          m_busy = 0, m_isdiv = 0, m_signed = 0, m_done = 0;
   int          m_left = 0;
   logic [63:0] m_res = 64'd0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_a = 32'd0, m_b = 32'd0;

   initial forever begin
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) begin
         m_busy = 0; m_done = 0; m_isdiv = 0; m_signed = 0;
         m_hi = 32'd0; m_lo = 32'd0; m_a = 32'd0; m_b = 32'd0;
      end else if (m_done) begin
         m_done = 0;
      end else if (!m_busy) begin
         if (start_i && !flush_i) begin
            m_a = opa_i;
            m_b = opb_i;
            if (!op_i[1]) begin
               m_busy = 1; m_isdiv = 0; m_left = 2;
               m_res = mul_ref(op_i, opa_i, opb_i);
            end else if (FAST && opb_i == 32'd0) begin
               m_done = 1; m_hi = opa_i; m_lo = 32'hFFFF_FFFF;
            end else begin
               m_busy = 1; m_isdiv = 1; m_signed = (op_i == 2'b10);
            end
         end
      end else if (flush_i) begin
         m_busy = 0;
      end else if (m_isdiv) begin
         if (div_ready_i) begin
            m_busy = 0; m_done = 1;
            {m_hi, m_lo} = div_result_i;
         end
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 0; m_done = 1;
            {m_hi, m_lo} = m_res;
         end
      end
   end

   // Per-cycle comparison of every output against the model
   initial forever begin
      @(negedge clk);
      check("stall", stall_o, rst_ni && (m_busy || (!m_done && start_i && !flush_i)));
      check("done", done_o, m_done);
      check("div_start", div_start_o, m_busy && m_isdiv && !flush_i);
      check("div_annul", div_annul_o, m_busy && m_isdiv && flush_i);
      check("div_signed", div_signed_o, m_busy && m_isdiv && m_signed);
      check("hi", hi_o, m_hi);
      check("lo", lo_o, m_lo);
      check("div_a", div_a_o, m_a);
      check("div_b", div_b_o, m_b);
   end

   // ---------------- divider environment ----------------
   int dv_lat = 5;
   int dv_cnt = 0;
   bit dv_busy = 0;

   initial forever begin
      @(posedge clk);
      #2;
      div_ready_i = 1'b0;
      if (!rst_ni) begin
         dv_busy = 0;
      end else if (div_start_o || div_annul_o) begin
         if (!dv_busy) begin
            dv_busy = 1;
            dv_cnt = 0;
         end
         dv_cnt++;
         if (dv_cnt == dv_lat) begin
            div_ready_i  = 1'b1;
            div_result_i = div_ref(div_signed_o, div_a_o, div_b_o);
            dv_busy = 0;
         end
         if (div_annul_o) dv_busy = 0;
      end else begin
         dv_busy = 0;
      end
   end

   // ---------------- driver ----------------
   int done_cyc, stall_cyc;
   bit seen_start, seen_signed, seen_annul;

   // Issue one operation at cycle offset 0 (called 1 time unit after a rising edge, FSM idle)
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int flush_at);
      int c;
      c = 0;
      start_i = 1'b1; op_i = op; opa_i = a; opb_i = b; flush_i = 1'b0; dv_lat = lat;
      done_cyc = -1; stall_cyc = 0;
      seen_start = 0; seen_signed = 0; seen_annul = 0;
      forever begin
         #2;
         if (stall_o) stall_cyc++;
         if (div_start_o) seen_start = 1;
         if (div_signed_o) seen_signed = 1;
         if (div_annul_o) seen_annul = 1;
         if (done_o) begin
            done_cyc = c;
            break;
         end
         if (flush_i) begin
            @(posedge clk); #1;
            flush_i = 1'b0;
            break;
         end
         if (c >= 120) begin
            check("done_timeout", c, 64'd0);
            start_i = 1'b0;
            break;
         end
         @(posedge clk); #1;
         c++;
         if (c == flush_at) begin
            flush_i = 1'b1;
            start_i = 1'b0;
         end
      end
   endtask

   task automatic next_cycle();
      start_i = 1'b0;
      flush_i = 1'b0;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] pick_operand(input bit allow_zero);
      case ($urandom_range(0, 7))
         0: return allow_zero ? 32'd0 : 32'd1;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return $urandom_range(1, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          rlat, rfl;

      #1 rst_ni = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", hi_o, 32'd0);
      check("rst_lo", lo_o, 32'd0);
      check("rst_stall", stall_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      rst_ni = 1'b1;
      next_cycle();

      // MULT -2 * 3
      run_op(2'b00, 32'hFFFF_FFFE, 32'd3, 5, -1);
      check("mult_done_cyc", done_cyc, 3);
      check("mult_stall_cyc", stall_cyc, 3);
      check("mult_hi", hi_o, 32'hFFFF_FFFF);
      check("mult_lo", lo_o, 32'hFFFF_FFFA);
      next_cycle();

      // MULTU max * max
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, -1);
      check("multu_hi", hi_o, 32'hFFFF_FFFE);
      check("multu_lo", lo_o, 32'h0000_0001);
      next_cycle();

      // DIV -7 / 2 with a 34-cycle divider
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 34, -1);
      check("div_signed_seen", seen_signed, 1'b1);
      check("div_done_cyc", done_cyc, 35);
      check("div_stall_cyc", stall_cyc, 35);
      check("div_hi", hi_o, 32'hFFFF_FFFF);
      check("div_lo", lo_o, 32'hFFFF_FFFD);
      next_cycle();

      // DIVU flushed in DIV_WAIT cycle 10, then flush coinciding with ready
      run_op(2'b11, 32'd100, 32'd7, 40, 10);
      check("flush_no_done", done_cyc, -1);
      check("flush_annul_seen", seen_annul, 1'b1);
      check("flush_signed_seen", seen_signed, 1'b0);
      next_cycle();
      run_op(2'b11, 32'd100, 32'd7, 10, 10);
      check("flush_rdy_no_done", done_cyc, -1);
      check("flush_rdy_annul", seen_annul, 1'b1);
      next_cycle();
      next_cycle();
      check("flush_hi_kept", hi_o, 32'hFFFF_FFFF);
      check("flush_lo_kept", lo_o, 32'hFFFF_FFFD);

      // Flush in IDLE blocks acceptance
      start_i = 1'b1; op_i = 2'b00; opa_i = 32'd4; opb_i = 32'd4; flush_i = 1'b1;
      #2 check("idle_flush_stall", stall_o, 1'b0);
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      #2 check("idle_flush_not_busy", stall_o, 1'b0);
      @(posedge clk); #1;

      // Division by zero
      run_op(2'b11, 32'd9, 32'd0, 5, -1);
      check("div0_done_cyc", done_cyc, FAST ? 1 : 6);
      check("div0_start_seen", seen_start, !FAST);
      check("div0_hi", hi_o, 32'd9);
      check("div0_lo", lo_o, 32'hFFFF_FFFF);
      next_cycle();

      // Reset during MUL1
      start_i = 1'b1; op_i = 2'b01; opa_i = 32'd7; opb_i = 32'd9;
      @(posedge clk); #1;
      rst_ni = 1'b0;
      #1;
      check("rstmid_stall", stall_o, 1'b0);
      check("rstmid_done", done_o, 1'b0);
      check("rstmid_hi", hi_o, 32'd0);
      check("rstmid_lo", lo_o, 32'd0);
      check("rstmid_div_a", div_a_o, 32'd0);
      check("rstmid_div_b", div_b_o, 32'd0);
      check("rstmid_ctl", {div_start_o, div_signed_o, div_annul_o}, 3'b000);
      start_i = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b1;
      next_cycle();
      run_op(2'b01, 32'd5, 32'd6, 5, -1);
      check("post_rst_hi", hi_o, 32'd0);
      check("post_rst_lo", lo_o, 32'd30);
      check("post_rst_done_cyc", done_cyc, 3);
      next_cycle();

      // Randomized traffic, including start held through DONE and flushes in DONE
      for (int n = 0; n < 300; n++) begin
         rop  = 2'($urandom_range(0, 3));
         ra   = pick_operand(1'b1);
         rb   = pick_operand(($urandom_range(0, 5) == 0));
         rlat = $urandom_range(1, 40);
         rfl  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, rop[1] ? rlat : 2) : -1;
         run_op(rop, ra, rb, rlat, rfl);
         if (done_cyc >= 0) begin
            if ($urandom_range(0, 1) == 0) start_i = 1'b0;
            flush_i = ($urandom_range(0, 3) == 0);
         end
         @(posedge clk); #1;
         start_i = 1'b0;
         flush_i = 1'b0;
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni, input, 1: asynchronous reset, active-low.
REQ-003 SHALL have port start_i, input, 1: EX requests a HI/LO operation; held high while stalled.
REQ-004 SHALL have port op_i, input, 2: operation code; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports opa_i and opb_i, input, 32 each: rs and rt operands.
REQ-006 SHALL have port flush_i, input, 1: exception or pipeline flush; kills any operation in flight.
REQ-007 SHALL have port stall_o, output, 1: freezes the pipeline until the result is ready.
REQ-008 SHALL have port done_o, output, 1: one-cycle pulse when hi_o and lo_o hold a new result.
REQ-009 SHALL have ports hi_o and lo_o, output, 32 each: registered result.
REQ-010 SHALL have ports div_start_o, div_signed_o and div_annul_o, output, 1 each: control signals to the external divider.
REQ-011 SHALL have ports div_a_o and div_b_o, output, 32 each: latched dividend and divisor.
REQ-012 SHALL have port div_ready_i, input, 1: divider result valid.
REQ-013 SHALL have port div_result_i, input, 64: divider result, {remainder, quotient}.

Function
REQ-014 SHALL use FSM states IDLE, MUL1, MUL2, DIV_WAIT and DONE; the only path from DONE is to IDLE.
REQ-015 In IDLE, start_i=1 with flush_i=0 SHALL latch op_i, opa_i and opb_i, then move to MUL1 for ops 0x or to DIV_WAIT for ops 1x.
REQ-016 stall_o SHALL equal (IDLE & start_i & ~flush_i) | MUL1 | MUL2 | DIV_WAIT, combinationally; it SHALL be 0 in DONE.
REQ-017 Multiply path:
- MUL1 registers the 64-bit product: two's-complement signed for MULT, unsigned for MULTU.
- MUL2 is a pipeline slot, then DONE.
- done_o is high exactly 3 cycles after the accepting edge.
REQ-018 In DIV_WAIT:
- div_start_o=1; div_signed_o=1 for DIV only; div_a_o and div_b_o carry the latched operands.
- div_ready_i=1 moves the FSM to DONE and captures hi=div_result_i[63:32], lo=div_result_i[31:0].
REQ-019 hi_o and lo_o SHALL change only on the edge entering DONE: for multiply, hi = product[63:32] and lo = product[31:0]; they hold their value otherwise.
REQ-020 done_o SHALL be 1 only in DONE, for exactly one cycle.
REQ-021 start_i in DONE SHALL be ignored; a new operation is accepted no earlier than the following IDLE cycle.
REQ-022 Flush:
- flush_i=1 in MUL1, MUL2 or DIV_WAIT returns the FSM to IDLE on the next edge; no done_o pulse; hi_o and lo_o unchanged.
- In DIV_WAIT, div_annul_o=1 combinationally in that flush cycle and div_start_o=0.
REQ-023 flush_i and div_ready_i high together in DIV_WAIT SHALL give priority to flush: no capture, no done_o.
REQ-024 flush_i in IDLE SHALL block acceptance; flush_i in DONE SHALL have no effect, because the result is already committed.
REQ-025 div_annul_o SHALL be 0 in every case not covered by REQ-022.

Reset
REQ-026 rst_ni=0 SHALL immediately force:
- FSM to IDLE;
- hi_o, lo_o, div_a_o and div_b_o to 0;
- stall_o, done_o, div_start_o, div_signed_o and div_annul_o to 0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation without an annul pulse; the divider is reset by the same rst_ni.

Configuration
REQ-028 Macro MULDIV_DIV0_FAST_EN SHALL control division by zero.
- Defined: DIV or DIVU with opb_i=0 goes from IDLE directly to DONE and never asserts div_start_o; hi=opa, lo=32'hFFFF_FFFF; done_o is high 1 cycle after acceptance.
- Undefined: a zero divisor follows the normal DIV_WAIT path and the result is whatever the divider returns.

Verification
REQ-029 MULT with opa=32'hFFFF_FFFE (-2), opb=3 -> stall 3 cycles; done_o on cycle 3; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
REQ-030 MULTU with opa=opb=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-031 DIV with opa=-7, opb=2, divider model ready after 34 cycles -> div_signed_o=1; stall held until ready; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFD.
REQ-032 DIVU started, then flush_i pulsed in DIV_WAIT cycle 10 -> div_annul_o pulse, FSM in IDLE, no done_o, hi_o and lo_o unchanged; also repeat with flush_i and div_ready_i high in the same cycle.
REQ-033 rst_ni dropped during MUL1 -> all outputs 0 immediately; after release, a fresh MULTU with 5x6 gives lo=30.
REQ-034 With MULDIV_DIV0_FAST_EN defined, DIVU with opa=9, opb=0 -> div_start_o never high; done_o 1 cycle after acceptance; hi=9, lo=32'hFFFF_FFFF.
